// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared encodings for the bit-serial adder/subtractor sequencer.
package bit_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bit_serial_adder_ctrl_fa.sv
// Single-bit full-adder cell, time-shared by the serial controller.
module bit_serial_adder_ctrl_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Sequencer adding or subtracting two WIDTH-bit operands LSB first, one bit per clock,
// through one shared full-adder cell; start/busy/done handshake to the neuron controller.
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sh_r;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_sh_r_next;

    bit_serial_adder_ctrl_fa u_fa (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_sh_r_next = {w_sum, r_sh_r[WIDTH-1:1]};

    // Controller FSM: owns every register; subtraction is A + ~B + 1 via the carry seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_sh_r      <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh_a  <= op_a;
                        r_sh_b  <= (sub == OP_SUB) ? ~op_b : op_b;
                        r_sh_r  <= '0;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
                    r_sh_r  <= w_sh_r_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // On the MSB step r_carry is the carry into the MSB.
                    if (r_cnt == CNT_LAST) begin
                        r_result    <= w_sh_r_next;
                        r_carry_out <= w_cout;
                        r_overflow  <= r_carry ^ w_cout;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench: random and directed WIDTH=8 ops with mid-run resets, then WIDTH=4 exhaustive.
module tb_bit_serial_adder_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8;
    logic        start4;
    logic        sub;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        busy8, done8, co8, ov8;
    logic [7:0]  res8;
    logic        busy4, done4, co4, ov4;
    logic [3:0]  res4;

    exp_t        q[$];
    int          cyc = 0;
    logic        rst_seen = 1'b0;
    int          phase = 1;
    int          n_vec = 0;
    int          n_err = 0;
    int          a_last;
    logic [31:0] last_res [2];
    logic        last_co  [2];
    logic        last_ov  [2];

    logic [7:0]  dir_a [4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
    logic [7:0]  dir_b [4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
    logic        dir_s [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub),
        .op_a(op_a[7:0]), .op_b(op_b[7:0]),
        .busy(busy8), .done(done8), .result(res8), .carry_out(co8), .overflow(ov8)
    );

    bit_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub),
        .op_a(op_a[3:0]), .op_b(op_b[3:0]),
        .busy(busy4), .done(done4), .result(res4), .carry_out(co4), .overflow(ov4)
    );

    // Arithmetic reference: unsigned result/carry and signed-range overflow.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input int due);
        exp_t   r;
        longint m, ua, ub, sa, sb, t;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            r.res = 32'((ua - ub + m) % m);
            r.co  = (ua >= ub);
            t     = sa - sb;
        end else begin
            r.res = 32'((ua + ub) % m);
            r.co  = (ua + ub >= m);
            t     = sa + sb;
        end
        r.ov  = (t < -(m / 2)) || (t >= m / 2);
        r.due = due;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (phase %0d cycle %0d)", name, act, exp, phase, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    logic        m_busy, m_done, m_co, m_ov, m_exp_busy;
    logic [31:0] m_res;
    int          m_ix, m_w;
    exp_t        m_e;

    // Monitor: compares the active DUT against the scoreboard every falling edge.
    always @(negedge clk) begin
        m_ix   = (phase == 1) ? 0 : 1;
        m_w    = (phase == 1) ? 8 : 4;
        m_busy = (phase == 1) ? busy8 : busy4;
        m_done = (phase == 1) ? done8 : done4;
        m_co   = (phase == 1) ? co8 : co4;
        m_ov   = (phase == 1) ? ov8 : ov4;
        m_res  = (phase == 1) ? 32'(res8) : 32'(res4);
        if (rst_seen) begin
            q.delete();
            for (int i = 0; i < 2; i++) begin
                last_res[i] = 32'd0;
                last_co[i]  = 1'b0;
                last_ov[i]  = 1'b0;
            end
            check("rst_busy", m_busy, 0);
            check("rst_done", m_done, 0);
            check("rst_result", m_res, 0);
            check("rst_carry", m_co, 0);
            check("rst_ovf", m_ov, 0);
        end else begin
            m_exp_busy = (q.size() > 0) && (cyc >= q[0].due - m_w) && (cyc < q[0].due);
            check("busy", m_busy, m_exp_busy);
            if (q.size() > 0 && cyc == q[0].due) begin
                m_e = q.pop_front();
                check("done_latency", m_done, 1);
                check("result", m_res, m_e.res);
                check("carry_out", m_co, m_e.co);
                check("overflow", m_ov, m_e.ov);
                last_res[m_ix] = m_e.res;
                last_co[m_ix]  = m_e.co;
                last_ov[m_ix]  = m_e.ov;
            end else begin
                check("spurious_done", m_done, 0);
                check("hold_result", m_res, last_res[m_ix]);
                check("hold_carry", m_co, last_co[m_ix]);
                check("hold_ovf", m_ov, last_ov[m_ix]);
            end
        end
    end

    initial begin
        int k;
        int t;
        rst_n  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        sub    = 1'b0;
        op_a   = 32'd0;
        op_b   = 32'd0;
        a_last = -100;
        for (int i = 0; i < 2; i++) begin
            last_res[i] = 32'd0;
            last_co[i]  = 1'b0;
            last_ov[i]  = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        k = 0;
        while (k < 300) begin
            @(negedge clk);
            if (cyc + 1 >= a_last + 10) begin
                if (k < 4 || $urandom_range(0, 2) != 0) begin
                    if (k < 4) begin
                        op_a = 32'(dir_a[k]);
                        op_b = 32'(dir_b[k]);
                        sub  = dir_s[k];
                    end else begin
                        op_a = $urandom;
                        op_b = $urandom;
                        sub  = 1'($urandom_range(0, 1));
                    end
                    start8 = 1'b1;
                    q.push_back(model(8, op_a, op_b, sub, cyc + 1 + 8));
                    a_last = cyc + 1;
                    k++;
                    if (k == 20 || k == 150) begin
                        repeat (3) begin
                            @(negedge clk);
                            start8 = 1'b0;
                        end
                        rst_n = 1'b0;
                        @(negedge clk);
                        rst_n  = 1'b1;
                        a_last = -100;
                    end
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                // Requests and operand changes while busy must be ignored.
                start8 = 1'($urandom_range(0, 1));
                op_a   = $urandom;
                op_b   = $urandom;
                sub    = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        phase  = 2;
        a_last = -100;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    while (cyc + 1 < a_last + 6) @(negedge clk);
                    op_a   = 32'(a);
                    op_b   = 32'(b);
                    sub    = 1'(s);
                    start4 = 1'b1;
                    q.push_back(model(4, op_a, op_b, sub, cyc + 1 + 4));
                    a_last = cyc + 1;
                end
            end
        end
        @(negedge clk);
        start4 = 1'b0;

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(q.size()), 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
